// File: rtl/adma_pkg.sv
// Shared types and default widths for the per-channel descriptor queue.
// No logic; widths here set the layout of adma_desc_t.
// The 2D fields (ylen, strides) are only stored when ADMA_DESC_QUEUE_2D_EN is defined.
package adma_pkg;

    localparam int ADMA_DESC_DEPTH = 4;
    localparam int ADMA_LENGTH_W   = 16;
    localparam int ADMA_SRC_ADDR_W = 32;
    localparam int ADMA_DST_ADDR_W = 32;
    localparam int ADMA_XFER_ID_W  = $clog2(ADMA_DESC_DEPTH);

    typedef struct packed {
        logic [ADMA_SRC_ADDR_W-1:0] src;
        logic [ADMA_DST_ADDR_W-1:0] dst;
        logic [ADMA_LENGTH_W-1:0]   xlen;
        logic [ADMA_LENGTH_W-1:0]   ylen;
        logic [ADMA_LENGTH_W-1:0]   src_strd;
        logic [ADMA_LENGTH_W-1:0]   dst_strd;
    } adma_desc_t;

endpackage

// File: rtl/adma_desc_queue_if.sv
// Descriptor write (from CSR) and read (to transfer engine) channels.
// Pure wiring, no latency.
// Valid/ready on both channels; slave is the queue, master is the CSR/engine side.
interface adma_desc_queue_if #(
    parameter int DMA_LENGTH_W  = 16,
    parameter int SRC_ADDR_W    = 32,
    parameter int DST_ADDR_W    = 32,
    parameter int DMA_XFER_ID_W = 2
);
    logic                     desc_wr_vld_i;
    logic                     desc_wr_rdy_o;
    logic [SRC_ADDR_W-1:0]    desc_src_addr_i;
    logic [DST_ADDR_W-1:0]    desc_dst_addr_i;
    logic [DMA_LENGTH_W-1:0]  desc_xfer_xlen_i;
    logic [DMA_LENGTH_W-1:0]  desc_xfer_ylen_i;
    logic [DMA_LENGTH_W-1:0]  desc_src_strd_i;
    logic [DMA_LENGTH_W-1:0]  desc_dst_strd_i;

    logic                     desc_rd_vld_o;
    logic                     desc_rd_rdy_i;
    logic [DMA_XFER_ID_W-1:0] desc_rd_id_o;
    logic [SRC_ADDR_W-1:0]    desc_src_addr_o;
    logic [DST_ADDR_W-1:0]    desc_dst_addr_o;
    logic [DMA_LENGTH_W-1:0]  desc_xfer_xlen_o;
    logic [DMA_LENGTH_W-1:0]  desc_xfer_ylen_o;
    logic [DMA_LENGTH_W-1:0]  desc_src_strd_o;
    logic [DMA_LENGTH_W-1:0]  desc_dst_strd_o;

    modport slave (
        input  desc_wr_vld_i, desc_src_addr_i, desc_dst_addr_i, desc_xfer_xlen_i,
               desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i, desc_rd_rdy_i,
        output desc_wr_rdy_o, desc_rd_vld_o, desc_rd_id_o, desc_src_addr_o, desc_dst_addr_o,
               desc_xfer_xlen_o, desc_xfer_ylen_o, desc_src_strd_o, desc_dst_strd_o
    );

    modport master (
        output desc_wr_vld_i, desc_src_addr_i, desc_dst_addr_i, desc_xfer_xlen_i,
               desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i, desc_rd_rdy_i,
        input  desc_wr_rdy_o, desc_rd_vld_o, desc_rd_id_o, desc_src_addr_o, desc_dst_addr_o,
               desc_xfer_xlen_o, desc_xfer_ylen_o, desc_src_strd_o, desc_dst_strd_o
    );
endinterface

// File: rtl/adma_desc_fifo.sv
// Slot array plus wrap-bit pointers; slot index doubles as the transfer ID.
// Write visible at the read side the cycle after it lands (first-word fall-through).
// No internal flow control: the caller never writes when full nor reads when empty.
module adma_desc_fifo
    import adma_pkg::*;
#(
    parameter int DEPTH = ADMA_DESC_DEPTH,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  adma_desc_t      wr_desc,
    input  logic            rd_en,
    output adma_desc_t      rd_desc,
    output logic [ID_W-1:0] wr_id,
    output logic [ID_W-1:0] rd_id,
    output logic            empty
);
    logic [ID_W:0] wr_ptr;
    logic [ID_W:0] rd_ptr;

    logic [ADMA_SRC_ADDR_W-1:0] src_mem  [DEPTH];
    logic [ADMA_DST_ADDR_W-1:0] dst_mem  [DEPTH];
    logic [ADMA_LENGTH_W-1:0]   xlen_mem [DEPTH];
`ifdef ADMA_DESC_QUEUE_2D_EN
    logic [ADMA_LENGTH_W-1:0]   ylen_mem [DEPTH];
    logic [ADMA_LENGTH_W-1:0]   sstr_mem [DEPTH];
    logic [ADMA_LENGTH_W-1:0]   dstr_mem [DEPTH];
`else
    logic unused_2d;
    assign unused_2d = ^{wr_desc.ylen, wr_desc.src_strd, wr_desc.dst_strd};
`endif

    assign wr_id = wr_ptr[ID_W-1:0];
    assign rd_id = rd_ptr[ID_W-1:0];
    assign empty = (wr_ptr == rd_ptr);

    // Pointer advance; the extra wrap bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (ID_W+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (ID_W+1)'(1);
        end
    end

    // Slot storage; contents are never read while stale, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            src_mem[wr_id]  <= wr_desc.src;
            dst_mem[wr_id]  <= wr_desc.dst;
            xlen_mem[wr_id] <= wr_desc.xlen;
`ifdef ADMA_DESC_QUEUE_2D_EN
            ylen_mem[wr_id] <= wr_desc.ylen;
            sstr_mem[wr_id] <= wr_desc.src_strd;
            dstr_mem[wr_id] <= wr_desc.dst_strd;
`endif
        end
    end

    // Head slot, forced to zero when empty so outputs are clean after reset.
    always_comb begin
        rd_desc = '0;
`ifndef ADMA_DESC_QUEUE_2D_EN
        rd_desc.ylen = ADMA_LENGTH_W'(1);
`endif
        if (!empty) begin
            rd_desc.src  = src_mem[rd_id];
            rd_desc.dst  = dst_mem[rd_id];
            rd_desc.xlen = xlen_mem[rd_id];
`ifdef ADMA_DESC_QUEUE_2D_EN
            rd_desc.ylen     = ylen_mem[rd_id];
            rd_desc.src_strd = sstr_mem[rd_id];
            rd_desc.dst_strd = dstr_mem[rd_id];
`endif
        end
    end
endmodule

// File: rtl/adma_desc_queue.sv
// Per-channel descriptor queue: buffers CSR descriptors, issues one at a time, tracks the active transfer.
// Accept-to-offer 1 cycle; status, done bitmap and irq pulses register on the handshake edge.
// wr_rdy drops when DEPTH slots are queued or active; issue holds while a transfer is active or chn_en_i is low. 2D fields: ADMA_DESC_QUEUE_2D_EN.
module adma_desc_queue
    import adma_pkg::*;
#(
    parameter int DMA_DESC_DEPTH = ADMA_DESC_DEPTH,
    parameter int DMA_LENGTH_W   = ADMA_LENGTH_W,
    parameter int SRC_ADDR_W     = ADMA_SRC_ADDR_W,
    parameter int DST_ADDR_W     = ADMA_DST_ADDR_W,
    localparam int DMA_XFER_ID_W = $clog2(DMA_DESC_DEPTH)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      chn_en_i,
    input  logic                      irq_msk_com_i,
    input  logic                      irq_msk_qed_i,
    adma_desc_queue_if.slave          desc_if,
    input  logic                      xfer_beat_i,
    input  logic                      xfer_cmpl_i,
    output logic [DMA_XFER_ID_W-1:0]  xfer_id_o,
    output logic [DMA_DESC_DEPTH-1:0] xfer_done_o,
    output logic [DMA_XFER_ID_W-1:0]  active_xfer_id_o,
    output logic [DMA_LENGTH_W-1:0]   active_xfer_len_o,
    output logic                      irq_com_o,
    output logic                      irq_qed_o
);
    localparam logic [DMA_XFER_ID_W:0] OCC_FULL = (DMA_XFER_ID_W+1)'(DMA_DESC_DEPTH);

    logic [DMA_XFER_ID_W:0]   occ;
    logic                     active_vld;
    logic                     fifo_empty;
    logic [DMA_XFER_ID_W-1:0] wr_id;
    logic [DMA_XFER_ID_W-1:0] rd_id;
    adma_desc_t               wr_desc;
    adma_desc_t               rd_desc;
    logic                     wr_fire;
    logic                     rd_fire;
    logic                     cmpl_fire;

    assign desc_if.desc_wr_rdy_o = (occ != OCC_FULL);
    assign desc_if.desc_rd_vld_o = chn_en_i && !fifo_empty && !active_vld;

    assign wr_fire   = desc_if.desc_wr_vld_i && desc_if.desc_wr_rdy_o;
    assign rd_fire   = desc_if.desc_rd_vld_o && desc_if.desc_rd_rdy_i;
    assign cmpl_fire = xfer_cmpl_i && active_vld;

    // Pack the incoming descriptor fields into one slot word.
    always_comb begin
        wr_desc          = '0;
        wr_desc.src      = desc_if.desc_src_addr_i;
        wr_desc.dst      = desc_if.desc_dst_addr_i;
        wr_desc.xlen     = desc_if.desc_xfer_xlen_i;
        wr_desc.ylen     = desc_if.desc_xfer_ylen_i;
        wr_desc.src_strd = desc_if.desc_src_strd_i;
        wr_desc.dst_strd = desc_if.desc_dst_strd_i;
    end

    adma_desc_fifo #(
        .DEPTH (DMA_DESC_DEPTH),
        .ID_W  (DMA_XFER_ID_W)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (wr_fire),
        .wr_desc (wr_desc),
        .rd_en   (rd_fire),
        .rd_desc (rd_desc),
        .wr_id   (wr_id),
        .rd_id   (rd_id),
        .empty   (fifo_empty)
    );

    assign desc_if.desc_rd_id_o     = rd_id;
    assign desc_if.desc_src_addr_o  = rd_desc.src;
    assign desc_if.desc_dst_addr_o  = rd_desc.dst;
    assign desc_if.desc_xfer_xlen_o = rd_desc.xlen;
    assign desc_if.desc_xfer_ylen_o = rd_desc.ylen;
    assign desc_if.desc_src_strd_o  = rd_desc.src_strd;
    assign desc_if.desc_dst_strd_o  = rd_desc.dst_strd;
    assign xfer_id_o                = wr_id;

    // Occupancy counts queued plus active slots, so a slot is freed only on completion.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                  occ <= '0;
        else if (wr_fire && !cmpl_fire) occ <= occ + (DMA_XFER_ID_W+1)'(1);
        else if (!wr_fire && cmpl_fire) occ <= occ - (DMA_XFER_ID_W+1)'(1);
    end

    // Active transfer tracking; issue and completion are mutually exclusive by construction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            active_vld        <= 1'b0;
            active_xfer_id_o  <= '0;
            active_xfer_len_o <= '0;
        end else if (rd_fire) begin
            active_vld        <= 1'b1;
            active_xfer_id_o  <= rd_id;
            active_xfer_len_o <= rd_desc.xlen;
        end else begin
            if (xfer_beat_i && active_vld && active_xfer_len_o != '0)
                active_xfer_len_o <= active_xfer_len_o - DMA_LENGTH_W'(1);
            if (cmpl_fire)
                active_vld <= 1'b0;
        end
    end

    // Done bitmap: cleared on refill, set on completion; the two never hit the same slot.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            xfer_done_o <= '0;
        end else begin
            if (wr_fire)   xfer_done_o[wr_id]            <= 1'b0;
            if (cmpl_fire) xfer_done_o[active_xfer_id_o] <= 1'b1;
        end
    end

    // Registered one-cycle interrupt pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_qed_o <= 1'b0;
            irq_com_o <= 1'b0;
        end else begin
            irq_qed_o <= wr_fire && irq_msk_qed_i;
            irq_com_o <= cmpl_fire && irq_msk_com_i;
        end
    end
endmodule

// File: tb/tb_adma_desc_queue.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based reference model.
module tb_adma_desc_queue;
    import adma_pkg::*;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        chn_en_i, irq_msk_com_i, irq_msk_qed_i, xfer_beat_i, xfer_cmpl_i;
    logic [1:0]  xfer_id_o, active_xfer_id_o;
    logic [3:0]  xfer_done_o;
    logic [15:0] active_xfer_len_o;
    logic        irq_com_o, irq_qed_o;

    always #5 aclk = ~aclk;

    adma_desc_queue_if #(.DMA_LENGTH_W(16), .SRC_ADDR_W(32), .DST_ADDR_W(32), .DMA_XFER_ID_W(2)) dif ();

    adma_desc_queue dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .chn_en_i          (chn_en_i),
        .irq_msk_com_i     (irq_msk_com_i),
        .irq_msk_qed_i     (irq_msk_qed_i),
        .desc_if           (dif),
        .xfer_beat_i       (xfer_beat_i),
        .xfer_cmpl_i       (xfer_cmpl_i),
        .xfer_id_o         (xfer_id_o),
        .xfer_done_o       (xfer_done_o),
        .active_xfer_id_o  (active_xfer_id_o),
        .active_xfer_len_o (active_xfer_len_o),
        .irq_com_o         (irq_com_o),
        .irq_qed_o         (irq_qed_o)
    );

    typedef struct {
        logic [31:0] src, dst;
        logic [15:0] xlen, ylen, ss, ds;
        int          id;
    } mdesc_t;

    mdesc_t   mq[$];
    int       m_next, m_aid, m_alen;
    bit       m_act, m_iq, m_ic;
    bit [3:0] m_done;
    int       n_pass = 0;
    int       n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_next = 0; m_aid = 0; m_alen = 0;
        m_act = 0; m_iq = 0; m_ic = 0; m_done = '0;
    endtask

    task automatic idle_inputs();
        dif.desc_wr_vld_i = 0; dif.desc_rd_rdy_i = 0;
        dif.desc_src_addr_i = '0; dif.desc_dst_addr_i = '0;
        dif.desc_xfer_xlen_i = '0; dif.desc_xfer_ylen_i = '0;
        dif.desc_src_strd_i = '0; dif.desc_dst_strd_i = '0;
        xfer_beat_i = 0; xfer_cmpl_i = 0;
    endtask

    task automatic set_desc(input logic [31:0] src, input logic [15:0] xlen);
        dif.desc_src_addr_i  = src;
        dif.desc_dst_addr_i  = $urandom;
        dif.desc_xfer_xlen_i = xlen;
        dif.desc_xfer_ylen_i = 16'($urandom);
        dif.desc_src_strd_i  = 16'($urandom);
        dif.desc_dst_strd_i  = 16'($urandom);
    endtask

    // Compare every output against the model, given the inputs currently applied.
    task automatic check_outputs();
        bit exp_rdy, exp_vld;
        #1;
        exp_rdy = (mq.size() + int'(m_act)) != DEPTH;
        exp_vld = chn_en_i && (mq.size() > 0) && !m_act;
        chk("wr_rdy", dif.desc_wr_rdy_o, exp_rdy);
        chk("rd_vld", dif.desc_rd_vld_o, exp_vld);
        if (exp_vld) begin
            chk("rd_id", dif.desc_rd_id_o, mq[0].id);
            chk("src", dif.desc_src_addr_o, mq[0].src);
            chk("dst", dif.desc_dst_addr_o, mq[0].dst);
            chk("xlen", dif.desc_xfer_xlen_o, mq[0].xlen);
`ifdef ADMA_DESC_QUEUE_2D_EN
            chk("ylen", dif.desc_xfer_ylen_o, mq[0].ylen);
            chk("sstrd", dif.desc_src_strd_o, mq[0].ss);
            chk("dstrd", dif.desc_dst_strd_o, mq[0].ds);
`else
            chk("ylen", dif.desc_xfer_ylen_o, 1);
            chk("sstrd", dif.desc_src_strd_o, 0);
            chk("dstrd", dif.desc_dst_strd_o, 0);
`endif
        end
        chk("xfer_id", xfer_id_o, m_next % DEPTH);
        chk("done", xfer_done_o, m_done);
        chk("act_id", active_xfer_id_o, m_aid);
        chk("act_len", active_xfer_len_o, m_alen);
        chk("irq_qed", irq_qed_o, m_iq);
        chk("irq_com", irq_com_o, m_ic);
    endtask

    // Advance the model by one clock using the applied inputs.
    task automatic model_update();
        bit wr, rd, cm;
        mdesc_t d;
        wr = dif.desc_wr_vld_i && ((mq.size() + int'(m_act)) != DEPTH);
        rd = dif.desc_rd_rdy_i && chn_en_i && (mq.size() > 0) && !m_act;
        cm = xfer_cmpl_i && m_act;
        m_iq = wr && irq_msk_qed_i;
        m_ic = cm && irq_msk_com_i;
        if (xfer_beat_i && m_act && m_alen > 0) m_alen--;
        if (cm) begin
            m_done[m_aid] = 1'b1;
            m_act = 0;
        end
        if (rd) begin
            m_act = 1;
            m_aid = mq[0].id;
            m_alen = int'(mq[0].xlen);
            void'(mq.pop_front());
        end
        if (wr) begin
            d.src = dif.desc_src_addr_i; d.dst = dif.desc_dst_addr_i;
            d.xlen = dif.desc_xfer_xlen_i; d.ylen = dif.desc_xfer_ylen_i;
            d.ss = dif.desc_src_strd_i; d.ds = dif.desc_dst_strd_i;
            d.id = m_next % DEPTH;
            m_done[d.id] = 1'b0;
            mq.push_back(d);
            m_next++;
        end
    endtask

    task automatic tick();
        check_outputs();
        model_update();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        aresetn = 0;
        #1;
        model_reset();
        chk("rst_wr_rdy", dif.desc_wr_rdy_o, 1);
        chk("rst_rd_vld", dif.desc_rd_vld_o, 0);
        chk("rst_rd_id", dif.desc_rd_id_o, 0);
        chk("rst_src", dif.desc_src_addr_o, 0);
        chk("rst_xlen", dif.desc_xfer_xlen_o, 0);
        chk("rst_xfer_id", xfer_id_o, 0);
        chk("rst_done", xfer_done_o, 0);
        chk("rst_act_id", active_xfer_id_o, 0);
        chk("rst_act_len", active_xfer_len_o, 0);
        chk("rst_irq", {irq_qed_o, irq_com_o}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1;
    endtask

    initial begin
        chn_en_i = 1; irq_msk_com_i = 1; irq_msk_qed_i = 1;
        idle_inputs();
        apply_reset();

        // One descriptor: ID 0 assigned, qed pulse, offered next cycle.
        set_desc(32'h1000, 16'd8);
        dif.desc_wr_vld_i = 1;
        tick();
        dif.desc_wr_vld_i = 0;
        chk("t1_xfer_id", xfer_id_o, 1);
        chk("t1_irq_qed", irq_qed_o, 1);
        chk("t1_rd_vld", dif.desc_rd_vld_o, 1);
        chk("t1_rd_id", dif.desc_rd_id_o, 0);

        // Fill to DEPTH, then a stalled fifth write.
        for (int i = 0; i < 3; i++) begin
            set_desc(32'h2000 + 32'(i), 16'd8);
            dif.desc_wr_vld_i = 1;
            tick();
        end
        chk("t2_full", dif.desc_wr_rdy_o, 0);
        tick();
        dif.desc_wr_vld_i = 0;
        chk("t2_stall_id", xfer_id_o, 0);
        dif.desc_rd_rdy_i = 1;
        tick();
        dif.desc_rd_rdy_i = 0;
        chk("t2_still_full", dif.desc_wr_rdy_o, 0);
        xfer_cmpl_i = 1;
        tick();
        xfer_cmpl_i = 0;
        chk("t2_rdy_back", dif.desc_wr_rdy_o, 1);
        chk("t2_irq_com", irq_com_o, 1);
        chk("t2_done", xfer_done_o, 4'b0001);

        // Beats count down and saturate.
        dif.desc_rd_rdy_i = 1;
        tick();
        dif.desc_rd_rdy_i = 0;
        xfer_beat_i = 1;
        repeat (3) tick();
        chk("t3_len5", active_xfer_len_o, 5);
        chk("t3_id", active_xfer_id_o, 1);
        repeat (10) tick();
        xfer_beat_i = 0;
        chk("t3_len0", active_xfer_len_o, 0);
        xfer_cmpl_i = 1;
        tick();
        xfer_cmpl_i = 0;
        chk("t3_done", xfer_done_o, 4'b0011);

        // Accept into slot 0 while slot 2 completes.
        dif.desc_rd_rdy_i = 1;
        tick();
        dif.desc_rd_rdy_i = 0;
        set_desc(32'h3000, 16'd4);
        dif.desc_wr_vld_i = 1;
        xfer_cmpl_i = 1;
        tick();
        dif.desc_wr_vld_i = 0;
        xfer_cmpl_i = 0;
        chk("t4_done", xfer_done_o, 4'b0110);
        tick();

        // Channel disabled holds issue; masks off suppress irqs.
        apply_reset();
        chn_en_i = 0; irq_msk_com_i = 0; irq_msk_qed_i = 0;
        dif.desc_wr_vld_i = 1;
        set_desc(32'h4000, 16'd3);
        tick();
        set_desc(32'h5000, 16'd3);
        tick();
        dif.desc_wr_vld_i = 0;
        chk("t5_no_irq_qed", irq_qed_o, 0);
        tick();
        chk("t5_hold", dif.desc_rd_vld_o, 0);
        chn_en_i = 1;
        dif.desc_rd_rdy_i = 1;
        tick();
        chk("t5_first", active_xfer_id_o, 0);
        xfer_cmpl_i = 1;
        tick();
        xfer_cmpl_i = 0;
        chk("t5_no_irq_com", irq_com_o, 0);
        tick();
        dif.desc_rd_rdy_i = 0;
        chk("t5_second", active_xfer_id_o, 1);

        // Reset mid-transfer, then the next write is ID 0 again.
        apply_reset();
        set_desc(32'h6000, 16'd2);
        dif.desc_wr_vld_i = 1;
        tick();
        dif.desc_wr_vld_i = 0;
        chk("t6_rd_id", dif.desc_rd_id_o, 0);
        chk("t6_xfer_id", xfer_id_o, 1);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) apply_reset();
            chn_en_i          = ($urandom_range(0, 7) != 0);
            irq_msk_com_i     = 1'($urandom_range(0, 1));
            irq_msk_qed_i     = 1'($urandom_range(0, 1));
            dif.desc_wr_vld_i = 1'($urandom_range(0, 1));
            set_desc($urandom, 16'($urandom_range(0, 12)));
            dif.desc_rd_rdy_i = 1'($urandom_range(0, 1));
            xfer_beat_i       = 1'($urandom_range(0, 1));
            xfer_cmpl_i       = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
